// File: rtl/sipo_deser_if.sv
// sipo_deser_if: serial input and parallel handshake bundle for the SIPO deserializer.
//    master: drives sin, sen, ack, ovr_clr; observes dout, dvalid, overrun, bit_cnt
//    slave : the deserializer side (mirror of master)
interface sipo_deser_if #(
   parameter int WIDTH = 4
);
   logic                     sin;
   logic                     sen;
   logic                     ack;
   logic                     ovr_clr;
   logic [WIDTH-1:0]         dout;
   logic                     dvalid;
   logic                     overrun;
   logic [$clog2(WIDTH)-1:0] bit_cnt;
   modport master (output sin, sen, ack, ovr_clr, input dout, dvalid, overrun, bit_cnt);
   modport slave  (input sin, sen, ack, ovr_clr, output dout, dvalid, overrun, bit_cnt);
endinterface

// File: rtl/sipo_deser.sv
// sipo_deser: serial-in parallel-out deserializer with valid/ack hold and sticky overrun.
//    clk    : rising-edge system clock
//    rst_n  : asynchronous active-low reset
//    bus    : sipo_deser_if.slave (sin, sen, ack, ovr_clr in; dout, dvalid, overrun, bit_cnt out)
module sipo_deser #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   sipo_deser_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);
   logic [WIDTH-1:0] sh, sh_nxt;
   logic             done;
   // sh_nxt includes the bit sampled on this edge, so a completing word is taken from it
   always_comb begin
      sh_nxt = MSB_FIRST ? {sh[WIDTH-2:0], bus.sin} : {bus.sin, sh[WIDTH-1:1]};
      done   = bus.sen && (bus.bit_cnt == CW'(WIDTH - 1));
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh          <= '0;
         bus.bit_cnt <= '0;
         bus.dout    <= '0;
         bus.dvalid  <= 1'b0;
         bus.overrun <= 1'b0;
      end else begin
         if (bus.sen) sh <= sh_nxt;
         bus.bit_cnt <= (bus.sen && !done) ? bus.bit_cnt + CW'(1) : '0;
         if (done) bus.dout <= sh_nxt;
         // a completion keeps dvalid high even when ack arrives on the same edge
         bus.dvalid  <= done || (bus.dvalid && !bus.ack);
         // setting beats clearing when both happen together
         bus.overrun <= (done && bus.dvalid && !bus.ack) || (bus.overrun && !bus.ovr_clr);
      end
   end
endmodule
